// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter, its four requesters and
// the downstream consumer of the shared 64-bit datapath.
interface mux4_rr_arbiter_if;
    logic [3:0] req;          // per-requester request, held until ack
    logic [1:0] sel;          // select for the shared 4:1 mux
    logic [3:0] grant;        // one-hot owner, zero when idle
    logic       bus_valid;    // shared datapath carries a transaction
    logic       down_done;    // downstream completes the transaction
    logic [3:0] ack;          // one-hot completion pulse to the owner
    logic       timeout_err;  // completion was a watchdog abort

    // Arbiter side.
    modport master (
        input  req,
        input  down_done,
        output sel,
        output grant,
        output bus_valid,
        output ack,
        output timeout_err
    );

    // Requesters plus downstream side.
    modport slave (
        output req,
        output down_done,
        input  sel,
        input  grant,
        input  bus_valid,
        input  ack,
        input  timeout_err
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 datapath mux.
// The grant is held for a whole transaction; a watchdog aborts transactions
// the downstream never completes (TIMEOUT = 0 disables it).
module mux4_rr_arbiter #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic             clk,
    input  logic             reset,
    mux4_rr_arbiter_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit               WDOG_EN  = (TIMEOUT != 0);
    // Counter value seen in the TIMEOUT-th BUSY cycle (counter is 0 in the first).
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    logic [1:0]       ptr;       // highest-priority requester for the next pick
    logic [1:0]       sel_q;     // current (or last) owner
    logic [3:0]       grant_q;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       pick;
    logic             pick_valid;
    logic             busy;
    logic             timeout_hit;
    logic             finish;

    // Rotating priority search: first set request at ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pick       = '0;
        pick_valid = 1'b0;
        // Walk from the farthest offset down so the nearest hit overwrites.
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[ptr + 2'(i)]) begin
                pick       = ptr + 2'(i);
                pick_valid = 1'b1;
            end
        end
    end

    assign busy        = (state == BUSY);
    // A real completion in the last allowed cycle wins over the abort.
    assign timeout_hit = WDOG_EN && busy && !bus.down_done && (cnt == CNT_LAST);
    assign finish      = busy && (bus.down_done || timeout_hit);

    assign bus.sel         = sel_q;
    assign bus.grant       = grant_q;
    assign bus.bus_valid   = busy;
    assign bus.ack         = finish ? grant_q : 4'b0000;
    assign bus.timeout_err = timeout_hit;

    // Arbitration FSM with registered select, grant, pointer and watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_valid) begin
                        state   <= BUSY;
                        sel_q   <= pick;
                        grant_q <= 4'b0001 << pick;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (finish) begin
                        // sel keeps its last value; only grant drops.
                        state   <= IDLE;
                        grant_q <= '0;
                        ptr     <= sel_q + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (TIMEOUT = 8).
// Stimulus changes on the falling edge; outputs are sampled 1 ns later.
module tb_mux4_rr_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .TIMEOUT (TO),
        .CNT_W   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];   // expected owner index per granted transaction

    // Wait (bounded) for bus_valid; reports how many falling edges it took.
    task automatic wait_busy(output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.bus_valid === 1'b1) begin
                seen   = 1'b1;
                waited = i;
                break;
            end
        end
    endtask

    // Drive one request pattern, complete after done_after BUSY cycles,
    // and capture what the DUT showed. No comparisons here.
    task automatic do_txn(input logic [3:0] r, input int done_after,
                          output bit seen, output logic [1:0] s,
                          output logic [3:0] g, output logic [3:0] a,
                          output logic te, output logic v_after);
        int w;
        s = 'x; g = 'x; a = 'x; te = 1'bx; v_after = 1'bx;
        bus.req       = r;
        bus.down_done = 1'b0;
        wait_busy(seen, w);
        if (!seen) begin
            bus.req = '0;
            return;
        end
        s = bus.sel;
        g = bus.grant;
        repeat (done_after - 1) @(negedge clk);
        bus.down_done = 1'b1;
        #1;
        a  = bus.ack;
        te = bus.timeout_err;
        @(negedge clk);
        bus.req       = '0;
        bus.down_done = 1'b0;
        #1;
        v_after = bus.bus_valid;
    endtask

    task automatic test_reset();
        bus.req       = '0;
        bus.down_done = 1'b1;
        reset         = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.sel, bus.grant, bus.bus_valid, bus.ack, bus.timeout_err} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got sel=%0d grant=%b valid=%b ack=%b terr=%b expected all 0",
                     bus.sel, bus.grant, bus.bus_valid, bus.ack, bus.timeout_err);
        end
        @(negedge clk);
        bus.down_done = 1'b0;
        reset         = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.down_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit seen;
        int w;
        int e;
        exp_q.push_back(0);
        bus.req = 4'b0001;
        wait_busy(seen, w);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || w != 1) begin
            n_fail++;
            $display("FAIL single_latency: got seen=%0d cycles=%0d expected seen=1 cycles=1", seen, w);
        end
        n_checks++;
        if ({bus.grant, bus.sel, bus.ack} !== {4'b0001 << e, 2'(e), 4'b0000}) begin
            n_fail++;
            $display("FAIL single_grant: got grant=%b sel=%0d ack=%b expected grant=0001 sel=0 ack=0000",
                     bus.grant, bus.sel, bus.ack);
        end
        repeat (2) @(negedge clk);
        bus.down_done = 1'b1;
        #1;
        n_checks++;
        if ({bus.ack, bus.timeout_err} !== {4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL single_ack: got ack=%b terr=%b expected ack=0001 terr=0", bus.ack, bus.timeout_err);
        end
        @(negedge clk);
        bus.down_done = 1'b0;
        bus.req       = '0;
        #1;
        n_checks++;
        if ({bus.grant, bus.bus_valid, bus.ack, bus.sel} !== {4'b0000, 1'b0, 4'b0000, 2'd0}) begin
            n_fail++;
            $display("FAIL single_idle: got grant=%b valid=%b ack=%b sel=%0d expected 0000/0/0000/0",
                     bus.grant, bus.bus_valid, bus.ack, bus.sel);
        end
    endtask

    task automatic test_round_robin();
        bit seen;
        int w;
        int e;
        apply_reset();
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_busy(seen, w);
            e = exp_q.pop_front();
            n_checks++;
            if (!seen || w != 1) begin
                n_fail++;
                $display("FAIL rr_gap[%0d]: got seen=%0d cycles=%0d expected seen=1 cycles=1", k, seen, w);
            end
            n_checks++;
            if (bus.sel !== 2'(e) || bus.grant !== (4'b0001 << e)) begin
                n_fail++;
                $display("FAIL rr_owner[%0d]: got sel=%0d grant=%b expected sel=%0d", k, bus.sel, bus.grant, e);
            end
            bus.down_done = 1'b1;
            #1;
            n_checks++;
            if (bus.ack !== (4'b0001 << e)) begin
                n_fail++;
                $display("FAIL rr_ack[%0d]: got %b expected owner %0d", k, bus.ack, e);
            end
            @(negedge clk);
            bus.down_done = 1'b0;
            if (k == 4) bus.req = '0;
            #1;
            n_checks++;
            if (bus.bus_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle[%0d]: got valid=%b expected 0", k, bus.bus_valid);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_quiet: got valid=%b expected 0", bus.bus_valid);
        end
    endtask

    task automatic test_pointer_skip();
        logic [3:0] pats [3] = '{4'b0010, 4'b1001, 4'b0001};
        bit seen;
        logic [1:0] s;
        logic [3:0] g, a;
        logic te, v;
        int e;
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int k = 0; k < 3; k++) begin
            do_txn(pats[k], 1, seen, s, g, a, te, v);
            e = exp_q.pop_front();
            n_checks++;
            if (!seen || s !== 2'(e) || g !== (4'b0001 << e) || a !== (4'b0001 << e) || v !== 1'b0) begin
                n_fail++;
                $display("FAIL ptr_skip[%0d]: got seen=%0d sel=%0d grant=%b ack=%b valid_after=%b expected sel=%0d",
                         k, seen, s, g, a, v, e);
            end
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int w;
        int e;
        int early;
        logic [1:0] s;
        logic [3:0] g, a;
        logic te, v;
        exp_q.push_back(2);
        bus.req       = 4'b0100;
        bus.down_done = 1'b0;
        wait_busy(seen, w);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || bus.sel !== 2'(e)) begin
            n_fail++;
            $display("FAIL to_grant: got seen=%0d sel=%0d expected sel=%0d", seen, bus.sel, e);
        end
        early = 0;
        for (int c = 1; c <= TO; c++) begin
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            if (c < TO) begin
                if (bus.ack !== 4'b0000 || bus.timeout_err !== 1'b0) early++;
            end else begin
                n_checks++;
                if (bus.ack !== 4'b0100 || bus.timeout_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL to_abort: got ack=%b terr=%b expected ack=0100 terr=1", bus.ack, bus.timeout_err);
                end
            end
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL to_early: got %0d early completion cycles expected 0", early);
        end
        @(negedge clk);
        bus.req = '0;
        #1;
        n_checks++;
        if (bus.bus_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_idle: got valid=%b terr=%b expected 0/0", bus.bus_valid, bus.timeout_err);
        end
        // Completion coinciding with the last allowed cycle is a normal finish.
        exp_q.push_back(2);
        do_txn(4'b0100, TO, seen, s, g, a, te, v);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || s !== 2'(e) || a !== 4'b0100 || te !== 1'b0 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL to_done_race: got sel=%0d ack=%b terr=%b valid_after=%b expected sel=2 ack=0100 terr=0",
                     s, a, te, v);
        end
    endtask

    task automatic test_stability();
        bit seen;
        int w;
        int e;
        exp_q.push_back(0);
        bus.req = 4'b0001;
        wait_busy(seen, w);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || bus.sel !== 2'(e) || bus.grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL stab_grant: got seen=%0d sel=%0d grant=%b expected sel=0 grant=0001",
                     seen, bus.sel, bus.grant);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.req = 4'($urandom_range(0, 15)) & 4'b1110;
            #1;
            n_checks++;
            if ({bus.sel, bus.grant, bus.bus_valid, bus.ack} !== {2'd0, 4'b0001, 1'b1, 4'b0000}) begin
                n_fail++;
                $display("FAIL stab_hold[%0d]: got sel=%0d grant=%b valid=%b ack=%b expected 0/0001/1/0000",
                         k, bus.sel, bus.grant, bus.bus_valid, bus.ack);
            end
        end
        @(negedge clk);
        bus.down_done = 1'b1;
        #1;
        n_checks++;
        if (bus.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL stab_ack: got %b expected 0001", bus.ack);
        end
        @(negedge clk);
        bus.req       = '0;
        bus.down_done = 1'b0;
        @(negedge clk);
        bus.down_done = 1'b1;
        #1;
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.bus_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: got ack=%b valid=%b terr=%b expected 0000/0/0",
                     bus.ack, bus.bus_valid, bus.timeout_err);
        end
        @(negedge clk);
        bus.down_done = 1'b0;
        #1;
        n_checks++;
        if (bus.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done_quiet: got valid=%b expected 0", bus.bus_valid);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        int w;
        int e;
        logic [1:0] s;
        logic [3:0] g, a;
        logic te, v;
        // Serve 2 so the pointer sits at 3 before the interrupted transaction.
        exp_q.push_back(2);
        do_txn(4'b0100, 1, seen, s, g, a, te, v);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || s !== 2'(e)) begin
            n_fail++;
            $display("FAIL ar_setup: got seen=%0d sel=%0d expected sel=2", seen, s);
        end
        bus.req = 4'b0100;
        wait_busy(seen, w);
        n_checks++;
        if (!seen || bus.sel !== 2'd2) begin
            n_fail++;
            $display("FAIL ar_busy: got seen=%0d sel=%0d expected sel=2", seen, bus.sel);
        end
        #2;
        reset         = 1'b1;
        bus.down_done = 1'b1;
        #1;
        n_checks++;
        if ({bus.sel, bus.grant, bus.bus_valid, bus.ack, bus.timeout_err} !== 12'h000) begin
            n_fail++;
            $display("FAIL ar_immediate: got sel=%0d grant=%b valid=%b ack=%b terr=%b expected all 0",
                     bus.sel, bus.grant, bus.bus_valid, bus.ack, bus.timeout_err);
        end
        @(negedge clk);
        reset         = 1'b0;
        bus.down_done = 1'b0;
        bus.req       = '0;
        // Pointer back at 0: 1 wins over 3.
        exp_q.push_back(1);
        do_txn(4'b1010, 1, seen, s, g, a, te, v);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || s !== 2'(e) || g !== 4'b0010 || a !== 4'b0010) begin
            n_fail++;
            $display("FAIL ar_ptr_restart: got sel=%0d grant=%b ack=%b expected sel=1 grant=0010 ack=0010",
                     s, g, a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_skip();
        test_timeout();
        test_stability();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation time %0t expected completion earlier", $time);
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 64-bit datapath mux (4:1 operand/bus select) among four requesters. It owns the 2-bit select fed to the shared 4-input mux and the valid/done handshake toward the downstream consumer (memory port or shared functional unit). It also enforces fairness and holds the grant for a whole transaction. A watchdog aborts transactions the downstream never completes.

## Interface
- `TIMEOUT`, default 256: maximum BUSY cycles before abort; 0 disables the watchdog.
- `CNT_W`, default 9: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately on assertion.
- `req`  in  4  per-requester request; held high until acknowledged.
- `sel`  out  2  select for the shared 4:1 mux; index of the current owner.
- `grant`  out  4  one-hot owner indication; all zero when idle.
- `bus_valid`  out  1  muxed datapath carries a valid transaction (== state BUSY).
- `down_done`  in  1  downstream completes the current transaction this cycle.
- `ack`  out  4  one-hot single-cycle completion pulse to the owner.
- `timeout_err`  out  1  single-cycle pulse, coincident with `ack`, when a transaction was aborted.

## Operation
- States: IDLE, BUSY.
- Priority pointer `ptr` (2 bits, reset 0) names the highest-priority requester. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- IDLE: if `req` != 0, pick the first set bit in search order, then register `owner`, `grant` = 1<<owner and `sel` = owner, and go to BUSY. Counter clears to 0. If `req` == 0, stay in IDLE.
- BUSY:
  - `bus_valid`=1. `sel`/`grant` remain stable for the whole transaction.
  - Counter increments each cycle.
  - `req` changes, including withdrawal by the owner, are ignored.
- Completion, when `down_done`=1 in BUSY:
  - `ack[owner]`=1 that cycle (combinational from `down_done` & state).
  - Next edge: state goes to IDLE, `grant` to 0, `ptr` to owner+1 (wraps 3 to 0).
  - `sel` holds its last value.
- Timeout, when `TIMEOUT`!=0, counter == `TIMEOUT`-1 and `down_done`=0:
  - Same cycle: `ack[owner]`=1 and `timeout_err`=1.
  - Next edge: same transition as completion, including the `ptr` update.
- `down_done` and the timeout condition in the same cycle: treated as a normal completion, `timeout_err`=0.
- `down_done` while IDLE is ignored, with no `ack`.
- Requesters must drop `req` on the edge after seeing their `ack`. A request still high in IDLE is a new request.
- Reset mid-transaction: immediately state=IDLE, `grant`=0, `ack`=0, `timeout_err`=0, `bus_valid`=0, `sel`=0, `ptr`=0, counter=0. The aborted transaction receives no `ack`.

## Timing
- Reset values: `sel`=0, `grant`=0, `bus_valid`=0, `ack`=0, `timeout_err`=0.
- Grant latency: `req` seen in IDLE at edge t gives `grant`/`sel`/`bus_valid` valid after edge t.
- Completion: `down_done` in cycle u gives `ack` in cycle u, and IDLE after edge u.
- Minimum turnaround: one IDLE cycle between transactions. With continuous requests, the next grant appears after edge u+1.
- Abort: `ack`+`timeout_err` in the `TIMEOUT`-th BUSY cycle.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,... Starvation is bounded at 3 transactions.
- `sel`, `grant`, `state`, `ptr` and the counter are registered. `ack` and `timeout_err` are combinational from registered state and `down_done`.

## Test plan
- Reset/single: hold `reset`, check all outputs 0. Release, `req`=0001 → `grant`=0001, `sel`=0 next cycle. `down_done` after 3 cycles → `ack`=0001 for one cycle, then `grant`=0.
- Round-robin: `req`=1111 held (each bit re-raised after ack), `down_done` one cycle into each transaction → `sel` sequence 0,1,2,3,0, each separated by one IDLE cycle.
- Pointer skip: `ptr`=2 (after serving 1), `req`=1001 → `grant`=1000 (`sel`=3). Next, with `req`=0001 → `sel`=0.
- Timeout: `TIMEOUT`=8, `req`=0100, never `down_done` → `ack`=0100 with `timeout_err`=1 in the 8th BUSY cycle, then IDLE. Also `down_done` exactly in the 8th cycle → `ack`, `timeout_err`=0.
- Stability/withdrawal: owner drops `req` and other `req` bits toggle during BUSY → `sel`/`grant` unchanged until `down_done`. `down_done` pulsed in IDLE → no `ack`.
- Async reset mid-BUSY: assert `reset` between edges → `grant`, `bus_valid`, `sel` go 0 immediately with no `ack`. After release, `req`=0010 → grant 0010 (`ptr` restarted at 0).
